// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl shared types: FSM encoding, access codes, default widths.
// Optional stats counters are enabled with RAM_CTRL_STATS_EN.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;

endpackage

// File: rtl/ram_ctrl_if.sv
// CPU-to-RAM port bundle between the cpu (master) and ram_ctrl (slave).
// Widths follow the cpu address/data buses.
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              ram_request;
  logic              mem_control;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              read_valid;
  logic              addr_error;
  logic              ready;

  modport master (
    output ram_request,
    output mem_control,
    output address,
    output ram_data_in,
    input  ram_data_out,
    input  read_valid,
    input  addr_error,
    input  ready
  );

  modport slave (
    input  ram_request,
    input  mem_control,
    input  address,
    input  ram_data_in,
    output ram_data_out,
    output read_valid,
    output addr_error,
    output ready
  );

endinterface

// File: rtl/ram_array.sv
// DEPTH x DATA_W single-port storage, synchronous write, registered read.
// Contents and read register are not reset; the controller clears them.
module ram_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // one port: write or registered read at the addressed word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
    if (re) rd_data <= mem[addr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// Data-memory controller: clears the array after reset, then serves the cpu.
// Define RAM_CTRL_STATS_EN to add saturating rd_count/wr_count outputs.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        rst,
  ram_ctrl_if.slave   bus
`ifdef RAM_CTRL_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST  = AW'(DEPTH - 1);

  state_t state;
  state_t state_nx;

  logic [AW-1:0]     clr_ptr;
  logic              in_range;
  logic              acc;
  logic              rd_req;
  logic              wr_req;
  logic              rd_hit;
  logic              wr_hit;
  logic              zero_out;
  logic              read_valid;
  logic              addr_error;

  logic              we;
  logic              re;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_q;

  // high address bits are never dropped: anything >= DEPTH is an error
  assign in_range = {1'b0, bus.address} < LIMIT;
  assign acc      = (state == SERVE) && bus.ram_request;
  assign rd_req   = acc && (bus.mem_control == MEM_READ);
  assign wr_req   = acc && (bus.mem_control == MEM_WRITE);
  assign rd_hit   = rd_req && in_range;
  assign wr_hit   = wr_req && in_range;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // leave INIT on the edge that clears the last word
  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:    if (clr_ptr == LAST) state_nx = SERVE;
      SERVE:   state_nx = SERVE;
      default: state_nx = INIT;
    endcase
  end

  // array port steering: clear writes in INIT, cpu accesses in SERVE
  always_comb begin
    we        = 1'b0;
    re        = 1'b0;
    arr_addr  = bus.address[AW-1:0];
    arr_wdata = bus.ram_data_in;
    unique case (state)
      INIT: begin
        we        = 1'b1;
        arr_addr  = clr_ptr;
        arr_wdata = '0;
      end
      SERVE: begin
        we = wr_hit;
        re = rd_hit;
      end
      default: ;
    endcase
  end

  // clear pointer walks the array once per INIT visit
  always_ff @(posedge clk) begin
    if (rst)                   clr_ptr <= '0;
    else if (state != INIT)    clr_ptr <= '0;
    else if (clr_ptr == LAST)  clr_ptr <= '0;
    else                       clr_ptr <= clr_ptr + 1'b1;
  end

  // one-cycle flags; zero_out masks the array register after reset
  // and after out-of-range reads, and holds across writes/idle
  always_ff @(posedge clk) begin
    if (rst) begin
      read_valid <= 1'b0;
      addr_error <= 1'b0;
      zero_out   <= 1'b1;
    end else begin
      read_valid <= rd_req;
      addr_error <= acc && !in_range;
      if (rd_req) zero_out <= !in_range;
    end
  end

  ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .we      (we),
    .re      (re),
    .addr    (arr_addr),
    .wr_data (arr_wdata),
    .rd_data (arr_q)
  );

  assign bus.ram_data_out = zero_out ? '0 : arr_q;
  assign bus.read_valid   = read_valid;
  assign bus.addr_error   = addr_error;
  assign bus.ready        = (state == SERVE);

`ifdef RAM_CTRL_STATS_EN
  // saturating access counters, cleared whenever the array is being cleared
  always_ff @(posedge clk) begin
    if (rst || state == INIT) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_hit && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_hit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
